sequencer_control: RTL and testbench
====================================

# sequencer_control

Control-pulse generator that sits directly downstream of the finite state automaton in the sequencer unit. It consumes the step index the automaton produces and latches the fetched instruction byte. For every step it emits the registered control strobes that drive the bus, registers and memory. At each instruction's final step it asserts a restart request back to the automaton.

## Interface
- `STEPS`, 24: number of automaton steps (the longest instruction); sets the `step` width.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `step`  in  5  current automaton step index, 0..STEPS-1.
- `data_bus`  in  8  memory data bus; sampled as the instruction at fetch step 3.
- `sel_pc`  out  1  drive PC onto the address bus.
- `mem_read`  out  1  memory read enable.
- `mem_write`  out  1  memory write enable.
- `ld_inst`  out  1  instruction-register load strobe.
- `sel_inc`  out  1  drive incrementer onto the address bus.
- `ld_pc`  out  1  PC load strobe.
- `reg_sel`  out  3  source register select for the execute phase (instruction bits [2:0]).
- `reg_ld`  out  1  destination register load strobe.
- `fsm_restart`  out  1  one-cycle pulse telling the automaton to return to step 0.
- `inst`  out  8  latched instruction byte.
- `illegal`  out  1  sticky: an undecodable opcode was fetched.
- `seq_error`  out  1  sticky: step sequence violation.

## Operation
- **Fetch, identical for all instructions:**
  - `sel_pc` is high on steps 0–3.
  - `mem_read` is high on steps 1–3.
  - `ld_inst` is high on step 3; `inst` captures `data_bus` at the same edge.
  - `sel_inc` is high on steps 4–5.
  - `ld_pc` is high on step 5.
- **Decode:** classes are decoded from `inst`, which is valid from step 4 onward.
  - MOV8, `00xxxxxx`: length 8; `reg_sel=inst[2:0]` on steps 6–7; `reg_ld` on step 7.
  - SETAB, `01xxxxxx`: length 8; `reg_ld` on step 7.
  - ALU, `1000xxxx`: length 8; `reg_ld` on step 7.
  - LOAD/STORE, `1001xxxx`, bit 3 = store:
    - length 12; `reg_sel=inst[2:0]` on steps 6–10.
    - load: `mem_read` on steps 8–10 and `reg_ld` on step 10.
    - store: `mem_write` on steps 8–10.
  - GOTO, `11xxxxxx`: length 24; fetches the 16-bit target.
    - steps 6–13 and 14–21 each repeat the fetch pattern: `sel_pc` +0..+3, `mem_read` +1..+3, `sel_inc` +4..+5, `ld_pc` +5.
    - `ld_pc` is high on step 23.
  - Anything else: length 8, no execute strobes, `illegal` set.
- **Terminal step:** `fsm_restart` is high for exactly the cycle after the terminal step (class length − 1) is sampled.
- **Step legality:** a legal `step` equals the previous sample, previous + 1, or 0 after `fsm_restart`.
  - Any other value sets `seq_error`.
  - On that cycle all strobes are forced low and `fsm_restart` is asserted.
- `illegal` and `seq_error` clear only on reset.

## Timing
- `step` is sampled on the rising clock edge; all outputs are registered, with one cycle of latency from `step` to strobe.
- A held `step` (automaton stalled) holds strobes at the values for that step; no edge detection is done.
- Reset values: all strobes 0, `reg_sel`=0, `inst`=0x00, `illegal`=0, `seq_error`=0, `fsm_restart`=0.
- Reset mid-instruction clears everything asynchronously. After release, the block treats the next sample as legal only if `step`=0; otherwise `seq_error` is set.
- `step` ≥ STEPS is illegal and sets `seq_error`.
- If `step` exceeds the current class length without a restart, `seq_error` is set and `fsm_restart` is asserted.
- `fsm_restart` and a new step 0 sample in the same cycle are legal.

## Configuration
- Macro: `SEQ_HALT_EN`.
  - **Defined:**
    - opcode `10101110` (HALT) decodes with length 8 and drives no execute strobes.
    - at its terminal step `fsm_restart` stays low, and an output `halted` (1 bit) goes high and stays high until reset.
    - while `halted`, all strobes are forced low.
  - **Undefined:** `10101110` is illegal and the `halted` port is absent.

## Test plan
- Reset released, `step` walks 0..7 with `data_bus`=0x05 at step 3 → `inst`=0x05; `ld_inst` one cycle after step 3; `reg_sel`=5 and `reg_ld` one cycle after step 7; `fsm_restart` one cycle after step 7.
- `data_bus`=0x90 (load) over steps 0..11 → `mem_read` on steps 1–3 and 8–10, `reg_ld` after step 10, `fsm_restart` after step 11, `mem_write` never high.
- `data_bus`=0xC0 (GOTO) over steps 0..23 → `ld_pc` after steps 5, 11, 19 and 23; `fsm_restart` only after step 23.
- `step` jumps 3→6 → `seq_error`=1, strobes low, `fsm_restart` pulsed; `seq_error` stays high through later legal instructions until reset.
- Reset asserted at step 9 of a load → outputs 0 immediately; release with `step`=0 → normal fetch, no error.
- `data_bus`=0xAE → with `SEQ_HALT_EN`, `halted`=1 after step 7, no restart, strobes low; without it, `illegal`=1 and restart after step 7.

Source files
------------

// File: rtl/sequencer_control.sv
// sequencer_control: registered control-strobe generator driven by the automaton step index
// Ports: clock/reset (async active-low); step, data_bus in; fetch/execute strobes
// (sel_pc, mem_read, mem_write, ld_inst, sel_inc, ld_pc, reg_sel, reg_ld),
// fsm_restart, latched inst, sticky illegal/seq_error out.
// SEQ_HALT_EN adds the HALT opcode 0xAE and the sticky halted output.
module sequencer_control #(
  parameter int STEPS = 24
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [$clog2(STEPS)-1:0] step,
  input  logic [7:0]               data_bus,
  output logic                     sel_pc,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     ld_inst,
  output logic                     sel_inc,
  output logic                     ld_pc,
  output logic [2:0]               reg_sel,
  output logic                     reg_ld,
  output logic                     fsm_restart,
  output logic [7:0]               inst,
  output logic                     illegal,
  output logic                     seq_error
`ifdef SEQ_HALT_EN
  ,
  output logic                     halted
`endif
);
  logic [$clog2(STEPS)-1:0] prev;
  logic first, halt_st;
  int s, p, last;
  logic mov, setab, alu, ls, go, hlt, bad_bus, ok, run;
  always_comb begin
    s = int'(step);
    p = int'(prev);
    mov = inst[7:6] == 2'b00;
    setab = inst[7:6] == 2'b01;
    alu = inst[7:4] == 4'b1000;
    ls = inst[7:4] == 4'b1001;
    go = inst[7:6] == 2'b11;
`ifdef SEQ_HALT_EN
    hlt = inst == 8'hAE;
    bad_bus = data_bus[7:5] == 3'b101 && data_bus != 8'hAE;
`else
    hlt = 1'b0;
    bad_bus = data_bus[7:5] == 3'b101;
`endif
    last = go ? 23 : ls ? 11 : 7;
    // after reset only step 0 is accepted; otherwise hold, advance, or restart
    ok = s < STEPS && s <= last && (first ? s == 0 : (s == p || s == p + 1 || (fsm_restart && s == 0)));
    run = ok && !halt_st;
  end
`ifdef SEQ_HALT_EN
  assign halted = halt_st;
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_pc <= 1'b0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      ld_inst <= 1'b0;
      sel_inc <= 1'b0;
      ld_pc <= 1'b0;
      reg_sel <= 3'd0;
      reg_ld <= 1'b0;
      fsm_restart <= 1'b0;
      inst <= 8'h00;
      illegal <= 1'b0;
      seq_error <= 1'b0;
      halt_st <= 1'b0;
      prev <= '0;
      first <= 1'b1;
    end else begin
      prev <= step;
      first <= 1'b0;
      sel_pc <= run && (s <= 3 || (go && ((s >= 6 && s <= 9) || (s >= 14 && s <= 17))));
      mem_read <= run && ((s >= 1 && s <= 3) || (go && ((s >= 7 && s <= 9) || (s >= 15 && s <= 17))) || (ls && !inst[3] && s >= 8 && s <= 10));
      mem_write <= run && ls && inst[3] && s >= 8 && s <= 10;
      ld_inst <= run && s == 3;
      sel_inc <= run && ((s >= 4 && s <= 5) || (go && (s == 10 || s == 11 || s == 18 || s == 19)));
      ld_pc <= run && (s == 5 || (go && (s == 11 || s == 19 || s == 23)));
      reg_sel <= run && ((mov && s >= 6 && s <= 7) || (ls && s >= 6 && s <= 10)) ? inst[2:0] : 3'd0;
      reg_ld <= run && (((mov || setab || alu) && s == 7) || (ls && !inst[3] && s == 10));
      if (run && s == 3) inst <= data_bus;
      illegal <= illegal || (run && s == 3 && bad_bus);
      seq_error <= seq_error || !ok;
      // a violation also kicks the automaton back to step 0
      fsm_restart <= !ok || (s == last && !hlt && !halt_st);
      halt_st <= halt_st || (ok && hlt && s == last);
    end
  end
endmodule

// File: tb/tb_sequencer_control.sv
// tb_sequencer_control: directed and randomized checks against a table-painting reference model
module tb_sequencer_control;
`ifdef SEQ_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [4:0] step = 5'd0;
  logic [7:0] data_bus = 8'h00;
  logic sel_pc, mem_read, mem_write, ld_inst, sel_inc, ld_pc, reg_ld, fsm_restart, illegal, seq_error, halted;
  logic [2:0] reg_sel;
  logic [7:0] inst;
  int passed = 0, total = 0, fails = 0;
  int m_prev;
  bit m_first, m_restart, m_illegal, m_err, m_halted;
  logic [7:0] m_inst;
  logic [22:0] exp_v;
  sequencer_control dut (
    .clock(clock), .reset(reset), .step(step), .data_bus(data_bus),
    .sel_pc(sel_pc), .mem_read(mem_read), .mem_write(mem_write), .ld_inst(ld_inst),
    .sel_inc(sel_inc), .ld_pc(ld_pc), .reg_sel(reg_sel), .reg_ld(reg_ld),
    .fsm_restart(fsm_restart), .inst(inst), .illegal(illegal), .seq_error(seq_error)
`ifdef SEQ_HALT_EN
    , .halted(halted)
`endif
  );
`ifndef SEQ_HALT_EN
  assign halted = 1'b0;
`endif
  always #5 clock = ~clock;
  function automatic int len(input logic [7:0] op);
    if (op[7:6] == 2'b11) return 24;
    if (op[7:4] == 4'b1001) return 12;
    return 8;
  endfunction
  function automatic bit undecodable(input logic [7:0] op);
    return op[7:5] == 3'b101 && !(HALT && op == 8'hAE);
  endfunction
  // per-step strobe table {sel_pc,mem_read,mem_write,ld_inst,sel_inc,ld_pc,reg_sel[2:0],reg_ld}
  function automatic logic [9:0] row(input logic [7:0] op, input int s);
    logic [9:0] t [24];
    int bases[$];
    for (int i = 0; i < 24; i++) t[i] = '0;
    bases.push_back(0);
    if (op[7:6] == 2'b11) begin bases.push_back(6); bases.push_back(14); t[23][4] = 1'b1; end
    foreach (bases[b]) for (int k = 0; k <= 5; k++) begin
      if (k <= 3) t[bases[b] + k][9] = 1'b1;
      if (k >= 1 && k <= 3) t[bases[b] + k][8] = 1'b1;
      if (k >= 4) t[bases[b] + k][5] = 1'b1;
      if (k == 5) t[bases[b] + k][4] = 1'b1;
      if (k == 3 && bases[b] == 0) t[3][6] = 1'b1;
    end
    if (op[7:6] == 2'b00) begin t[6][3:1] = op[2:0]; t[7][3:1] = op[2:0]; t[7][0] = 1'b1; end
    if (op[7:6] == 2'b01 || op[7:4] == 4'b1000) t[7][0] = 1'b1;
    if (op[7:4] == 4'b1001) begin
      for (int i = 6; i <= 10; i++) t[i][3:1] = op[2:0];
      for (int i = 8; i <= 10; i++) if (op[3]) t[i][7] = 1'b1; else t[i][8] = 1'b1;
      if (!op[3]) t[10][0] = 1'b1;
    end
    return t[s];
  endfunction
  function automatic logic [22:0] obs();
    return {halted, fsm_restart, seq_error, illegal, inst, sel_pc, mem_read, mem_write, ld_inst, sel_inc, ld_pc, reg_sel, reg_ld};
  endfunction
  task automatic check(input string tag);
    total++;
    assert (obs() === exp_v) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs(), exp_v);
    end
  endtask
  task automatic cyc(input int s, input logic [7:0] d);
    logic [9:0] r;
    int last;
    bit legal, hlt;
    step = 5'(s);
    data_bus = d;
    @(posedge clock);
    last = len(m_inst) - 1;
    legal = s < 24 && s <= last && (m_first ? s == 0 : (s == m_prev || s == m_prev + 1 || (m_restart && s == 0)));
    hlt = HALT && m_inst == 8'hAE;
    r = (legal && !m_halted) ? row(m_inst, s) : '0;
    if (legal && !m_halted && s == 3) begin
      m_inst = d;
      if (undecodable(d)) m_illegal = 1'b1;
    end
    if (!legal) m_err = 1'b1;
    m_restart = !legal || (s == last && !hlt && !m_halted);
    if (legal && hlt && s == last) m_halted = 1'b1;
    m_prev = s;
    m_first = 1'b0;
    exp_v = {m_halted, m_restart, m_err, m_illegal, m_inst, r};
    #1 check($sformatf("step%0d_inst%h", s, m_inst));
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1;
    {m_restart, m_illegal, m_err, m_halted} = '0;
    m_first = 1'b1;
    m_prev = 0;
    m_inst = 8'h00;
    exp_v = '0;
    check("reset");
    step = 5'd0;
    @(negedge clock);
    reset = 1'b1;
  endtask
  task automatic instr(input logic [7:0] op, input int n);
    for (int s = 0; s < n; s++) cyc(s, s == 3 ? op : 8'($urandom));
  endtask
  initial begin
    logic [7:0] op;
    int n;
    do_reset();
    instr(8'h05, 8);
    instr(8'h90, 12);
    instr(8'hC0, 24);
    instr(8'h98, 12);
    instr(8'h47, 8);
    instr(8'h83, 8);
    for (int s = 0; s <= 3; s++) cyc(s, s == 3 ? 8'h05 : 8'h00);
    cyc(6, 8'h00);
    instr(8'h12, 8);
    instr(8'h90, 12);
    do_reset();
    instr(8'h47, 8);
    cyc(8, 8'h00);
    cyc(0, 8'h00);
    do_reset();
    cyc(0, 8'h00);
    cyc(1, 8'h00);
    cyc(30, 8'h00);
    do_reset();
    instr(8'h90, 10);
    do_reset();
    instr(8'h90, 12);
    do_reset();
    cyc(2, 8'h00);
    instr(8'h3A, 8);
    do_reset();
    for (int k = 0; k < 40; k++) begin
      op = 8'($urandom);
      if (op == 8'hAE) op = 8'h00;
      n = len(op);
      for (int s = 0; s < n; s++) begin
        cyc(s, s == 3 ? op : 8'($urandom));
        if ($urandom_range(0, 5) == 0) cyc(s, s == 3 ? op : 8'($urandom));
        if (k > 25 && $urandom_range(0, 39) == 0) begin
          cyc(int'($urandom_range(0, 31)), 8'($urandom));
          break;
        end
      end
    end
    do_reset();
    instr(8'hAE, 8);
    cyc(7, 8'h00);
    cyc(7, 8'h00);
    instr(8'h05, 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
